// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the display scan controller
// and its double-dabble engine.
package display_pkg;
    typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_COMMIT} cv_state_t;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] OVF_GLYPH = 4'hF;
    function automatic int dd_dig(input int in_w);
        return (in_w * 3) / 10 + 1;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one bit per cycle, IN_W cycles after start.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DD_DIG = dd_dig(IN_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IN_W-1:0]           value,
    output logic                      done,
    output logic [DD_DIG*BCD_W-1:0]   bcd
);
    localparam int CW = $clog2(IN_W + 1);
    logic [IN_W-1:0]         sh;
    logic [CW-1:0]           cnt;
    logic [DD_DIG*BCD_W-1:0] adj;
    logic                    run;
    assign run  = cnt != '0;
    // done marks the edge that performs the final step
    assign done = cnt == CW'(1);
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DD_DIG; i++)
            adj[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] >= 4'd5 ? bcd[i*BCD_W +: BCD_W] + 4'd3 : bcd[i*BCD_W +: BCD_W];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh  <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (start) begin
            sh  <= value;
            bcd <= '0;
            cnt <= CW'(IN_W);
        end else if (run) begin
            {bcd, sh} <= {adj, sh} << 1;
            cnt       <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: value intake, BCD/hex conversion and multiplexed digit scan.
// Define LEADING_ZERO_BLANK_EN to darken digits above the most significant nonzero one.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int IN_W        = 16,
    parameter int NDIG        = 5,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_value,
    input  logic              in_hex,
    output logic              busy,
    output logic              ovf,
    output logic [BCD_W-1:0]  bcd,
    output logic [NDIG-1:0]   an
);
    localparam int DD = dd_dig(IN_W);
    localparam int XW = IN_W > BCD_W * NDIG ? IN_W : BCD_W * NDIG;
    localparam int DW = DD > NDIG ? DD : NDIG;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;

    cv_state_t              state, state_nx;
    logic [IN_W-1:0]        val_q;
    logic                   hex_q;
    logic                   xfer;
    logic                   eng_done;
    logic [DD*BCD_W-1:0]    eng_bcd;
    logic [XW-1:0]          hx;
    logic [DW*BCD_W-1:0]    dx;
    logic [NDIG*BCD_W-1:0]  nd, disp;
    logic [NDIG-1:0]        nlit, lit;
    logic                   novf, disp_valid;
    logic [RW-1:0]          rcnt;
    logic [IW-1:0]          idx;
    logic                   wrap;

    assign in_ready = state == CV_IDLE;
    assign busy     = !in_ready;
    assign xfer     = in_valid && in_ready;

    bin2bcd_seq #(.IN_W(IN_W), .DD_DIG(DD)) u_b2b (
        .clk   (clk),
        .rst   (rst),
        .start (xfer && !in_hex),
        .value (in_value),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    always_comb begin
        state_nx = state;
        state_nx = state == CV_IDLE  ? (xfer ? (in_hex ? CV_COMMIT : CV_SHIFT) : CV_IDLE) :
                   state == CV_SHIFT ? (eng_done ? CV_COMMIT : CV_SHIFT) : CV_IDLE;
    end

    // Commit image: digits, lit mask and overflow computed from the finished result
    always_comb begin
        hx   = XW'(val_q);
        dx   = (DW*BCD_W)'(eng_bcd);
        novf = hex_q ? (hx >> (BCD_W * NDIG)) != '0 : (dx >> (BCD_W * NDIG)) != '0;
        nd   = '0;
        for (int i = 0; i < NDIG; i++)
            nd[i*BCD_W +: BCD_W] = novf ? OVF_GLYPH : hex_q ? hx[i*BCD_W +: BCD_W] : dx[i*BCD_W +: BCD_W];
`ifdef LEADING_ZERO_BLANK_EN
        nlit = '0;
        begin
            logic seen;
            seen = novf;
            for (int i = NDIG - 1; i >= 0; i--) begin
                seen    = seen || i == 0 || nd[i*BCD_W +: BCD_W] != '0;
                nlit[i] = seen;
            end
        end
`else
        nlit = '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= CV_IDLE;
            val_q      <= '0;
            hex_q      <= 1'b0;
            disp       <= '0;
            lit        <= '0;
            ovf        <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                val_q <= in_value;
                hex_q <= in_hex;
            end
            if (state == CV_COMMIT) begin
                disp       <= nd;
                lit        <= nlit;
                ovf        <= novf;
                disp_valid <= 1'b1;
            end
        end
    end

    assign wrap = rcnt == RW'(REFRESH_DIV - 1);

    // Outputs are re-derived every cycle from the registered index and display
    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt <= '0;
            idx  <= '0;
            an   <= '1;
            bcd  <= '0;
        end else begin
            rcnt <= wrap ? '0 : rcnt + RW'(1);
            if (wrap)
                idx <= idx == IW'(NDIG - 1) ? '0 : idx + IW'(1);
            an  <= disp_valid ? ~(NDIG'(lit[idx]) << idx) : '1;
            bcd <= disp_valid ? disp[idx*BCD_W +: BCD_W] : '0;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench with a per-cycle arithmetic scan model.
module tb_display_scan_ctrl;
    localparam int IN_W = 16;
    localparam int NDIG = 4;
    localparam int R    = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_hex = 1'b0;
    logic [IN_W-1:0] in_value = '0;
    logic            in_ready, busy, ovf;
    logic [3:0]      bcd;
    logic [NDIG-1:0] an;

    always #5 clk = ~clk;

    display_scan_ctrl #(.IN_W(IN_W), .NDIG(NDIG), .REFRESH_DIV(R)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .in_hex   (in_hex),
        .busy     (busy),
        .ovf      (ovf),
        .bcd      (bcd),
        .an       (an)
    );

    typedef struct packed {
        logic [NDIG*4-1:0] dig;
        logic [NDIG-1:0]   lit;
        logic              ovf;
        int                lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   infl = 0;
    int   vectors = 0;
    int   errors = 0;

    function automatic exp_t model(input int unsigned v, input bit h);
        exp_t e;
        int unsigned base, radix;
        radix = h ? 16 : 10;
        e.ovf = h ? (v >> (4 * NDIG)) != 0 : v >= 10 ** NDIG;
        e.lat = h ? 1 : IN_W + 1;
        e.dig = '0;
        e.lit = '0;
        base  = 1;
        for (int i = 0; i < NDIG; i++) begin
            e.dig[4*i +: 4] = e.ovf ? 4'hF : 4'((v / base) % radix);
`ifdef LEADING_ZERO_BLANK_EN
            e.lit[i] = e.ovf || i == 0 || v >= base;
`else
            e.lit[i] = 1'b1;
`endif
            base = base * radix;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: expected scan output follows purely from cycle count and committed image
    initial begin
        int n, due, idx;
        bit mv, mo, prev_ready, r, x;
        logic [NDIG*4-1:0] md;
        logic [NDIG-1:0] ml, ea;
        logic [3:0] eb;
        n = 0; due = 0; mv = 0; mo = 0; prev_ready = 1; md = '0; ml = '0;
        forever begin
            @(posedge clk);
            r = rst;
            x = in_valid && prev_ready;
            @(negedge clk);
            if (!r) begin
                check("reset_an", an, {NDIG{1'b1}});
                check("reset_bcd", bcd, 0);
                check("reset_busy", busy, 0);
                check("reset_ready", in_ready, 1);
                check("reset_ovf", ovf, 0);
                n = 0; mv = 0; mo = 0; infl = 0; prev_ready = 1;
                exp_q.delete();
                continue;
            end
            n++;
            idx = ((n - 1) / R) % NDIG;
            ea = '1;
            if (mv && ml[idx]) ea[idx] = 1'b0;
            eb = mv ? md[4*idx +: 4] : 4'h0;
            check("an", an, ea);
            check("bcd", bcd, eb);
            check("busy_vs_ready", busy, !in_ready);
            if (x) begin
                if (exp_q.size() == 0) flag("unexpected_transfer");
                else begin
                    cur = exp_q.pop_front();
                    due = n + cur.lat;
                    infl = 1;
                end
            end
            if (in_ready && !prev_ready) begin
                if (!infl) flag("unexpected_commit");
                else begin
                    check("latency", n, due);
                    mv = 1; md = cur.dig; ml = cur.lit; mo = cur.ovf;
                    infl = 0;
                end
            end
            check("ovf", ovf, mo);
            prev_ready = in_ready;
        end
    end

    task automatic send(input logic [IN_W-1:0] v, input bit h);
        int k;
        k = 0;
        @(negedge clk);
        in_value = v;
        in_hex = h;
        in_valid = 1'b1;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            flag("send_timeout");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(v, h));
        @(negedge clk);
        in_valid = 1'b0;
        in_value = IN_W'($urandom);
        in_hex = 1'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) flag("idle_timeout");
    endtask

    task automatic idle(input int c);
        repeat (c) @(negedge clk);
    endtask

    initial begin
        logic [IN_W-1:0] v;
        bit h;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(3 * R);
        send(16'd1234, 0);  wait_idle(); idle(2 * NDIG * R);
        send(16'hBEEF, 1);  wait_idle(); idle(NDIG * R + 2);
        send(16'd65535, 0); wait_idle(); idle(NDIG * R + 1);
        send(16'd0, 0);     wait_idle(); idle(NDIG * R);
        send(16'd0, 1);     wait_idle(); idle(NDIG * R);
        send(16'h00A0, 1);  wait_idle(); idle(NDIG * R);
        send(16'd9999, 0);  wait_idle(); idle(NDIG * R);
        send(16'd10000, 0); wait_idle(); idle(NDIG * R);
        send(16'd5000, 0);
        idle(3);
        in_value = 16'd9; in_hex = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle(); idle(NDIG * R);
        send(16'd4321, 0);
        idle(5);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(2 * R);
        repeat (40) begin
            v = ($urandom_range(0, 3) == 0) ? IN_W'($urandom_range(0, 99)) : IN_W'($urandom_range(0, 65535));
            h = 1'($urandom_range(0, 1));
            send(v, h);
            if ($urandom_range(0, 1) == 1) wait_idle();
            idle($urandom_range(0, 2 * R));
        end
        wait_idle();
        idle(2 * NDIG * R);
        check("queue_drained", exp_q.size() + int'(infl), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
